inta_sequencer: RTL and testbench
=================================

# inta_sequencer

Sequences the CPU-side interrupt handshake for the 8259A-compatible controller. Takes the priority resolver's winning request, raises INT to the CPU, and counts the two 8086-mode INTA pulses. On the first pulse it commands the ISR bit set. On the second it drives the interrupt vector onto the data bus. In auto-EOI mode it also issues the ISR clear. It sits between the priority resolver / ISR register and the data-bus buffer.

## Interface
- INTA_TIMEOUT, 255: maximum cycles in ACK1 waiting for the second INTA rising edge before abort; 1..255.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- irq_valid  in  1  resolver reports an unmasked request that outranks in-service levels.
- irq_level  in  3  resolver's highest-priority level, 0..7.
- inta  in  1  CPU acknowledge, active-high, already synchronous to clk.
- vector_base  in  5  ICW2[7:3].
- aeoi  in  1  ICW4 auto-EOI enable.
- int_out  out  1  interrupt request to CPU.
- isr_set  out  1  one-cycle strobe: set ISR bit isr_level.
- isr_clr  out  1  one-cycle strobe: clear ISR bit isr_level (AEOI only).
- isr_level  out  3  level for isr_set/isr_clr.
- data_out  out  8  vector {vector_base, level}.
- data_oe  out  1  data-bus drive enable.
- spurious  out  1  one-cycle strobe: acknowledge with no valid request.
- busy  out  1  FSM not in IDLE.

## Operation
- Reset values: every output is 0; state is IDLE; latched level is 0; timeout counter is 0; inta_q is 0.
- Edge detection: register inta into inta_q. Rise = inta & ~inta_q. Fall = ~inta & inta_q.
- IDLE: if irq_valid, go to REQ.
- REQ: int_out=1.
  - irq_valid low with no rise: go to IDLE, int_out drops.
  - Rise with irq_valid: latch irq_level, pulse isr_set, go to ACK1.
  - Rise without irq_valid: latch level 7, pulse spurious, no isr_set, set spur flag, go to ACK1.
- ACK1: int_out=0 and data_oe=0 (first pulse is not driven).
  - Counter increments each cycle in ACK1.
  - A second rise, only counted after a fall has been seen, goes to ACK2.
  - Counter reaching INTA_TIMEOUT goes to IDLE. No vector is driven; the ISR bit stays set.
- ACK2: data_oe=1, data_out={vector_base, latched level}, held constant.
  - On fall: data_oe=0.
  - If aeoi and not spur: pulse isr_clr with the latched level.
  - Go to IDLE; clear the spur flag and the counter.
- Changes to irq_level or irq_valid after the first rise are ignored until IDLE.
- vector_base is sampled continuously in ACK2; it must be static during an acknowledge.

## Timing
- All outputs registered.
- The reaction to a sampled event is visible in the following cycle.
- irq_valid sampled high at edge k: int_out high from edge k+2 (k+1 enters REQ, output registered).
- inta first sampled high at edge n (REQ): isr_set/spurious high for exactly one cycle after edge n+1; int_out low from that same edge.
- Second-pulse rise sampled at edge m: data_oe high after edge m+1.
- Second-pulse fall sampled at edge p: data_oe low and isr_clr pulse after edge p+1; back in IDLE.
- A new request can raise int_out at the earliest 2 cycles after returning to IDLE.
- Rise and irq_valid deassert in the same REQ cycle: treat as spurious.
- reset has priority over every transition. Mid-acknowledge reset forces data_oe=0 and IDLE next edge; no isr_clr is emitted.
- inta high on entry to REQ (no rise): wait; a rise is required.

## Structure
- Shared package pic_pkg holds:
  - state enum {IDLE, REQ, ACK1, ACK2}
  - LEVEL_W=3
  - VEC_BASE_W=5
  - SPURIOUS_LEVEL=3'd7
- One sub-module: pic_edge_detect, which registers inta and outputs rise/fall; it is reusable for rd/wr strobes.
- FSM, latch, counter and output registers live in inta_sequencer.

## Test plan
- Normal, aeoi=0: irq_valid=1, irq_level=3, vector_base=5'h08, two INTA pulses. Required:
  - int_out rises, then falls after first rise
  - isr_set once with isr_level=3
  - data_out=8'h43 with data_oe only during pulse 2
  - no isr_clr
- AEOI: same with aeoi=1, irq_level=6, vector_base=5'h10. Required:
  - data_out=8'h86
  - isr_clr pulse with isr_level=6 one cycle after pulse-2 fall
- Spurious: irq_valid drops the same cycle inta rises. Required:
  - spurious pulse, no isr_set
  - data_out=vector_base:7
  - no isr_clr even with aeoi=1
- Timeout: INTA_TIMEOUT=10, single INTA pulse only. Required:
  - isr_set once
  - IDLE after 10 cycles in ACK1
  - data_oe never asserted, busy=0
- Level change and reset: irq_level changes 3→1 after the first rise; data_out still uses 3. Then assert reset during pulse 2: data_oe=0 and all outputs 0 the next cycle.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A-compatible interrupt controller blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK1,
        ACK2
    } state_t;

    localparam int LEVEL_W    = 3;
    localparam int VEC_BASE_W = 5;
    localparam int VEC_W      = VEC_BASE_W + LEVEL_W;
    localparam int CNT_W      = 8;

    localparam logic [LEVEL_W-1:0] SPURIOUS_LEVEL = 3'd7;

    // Vector placed on the data bus during the second acknowledge: ICW2[7:3] over the level.
    function automatic logic [VEC_W-1:0] make_vector(input logic [VEC_BASE_W-1:0] base,
                                                     input logic [LEVEL_W-1:0]    lvl);
        return {base, lvl};
    endfunction

endpackage

// File: rtl/inta_sequencer_if.sv
// CPU-side interrupt handshake bundle between resolver/ISR/CPU and the INTA sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; the CPU paces the handshake through inta.
interface inta_sequencer_if;
    import pic_pkg::*;

    // Toward the sequencer
    logic                  irq_valid;
    logic [LEVEL_W-1:0]    irq_level;
    logic                  inta;
    logic [VEC_BASE_W-1:0] vector_base;
    logic                  aeoi;

    // From the sequencer
    logic                  int_out;
    logic                  isr_set;
    logic                  isr_clr;
    logic [LEVEL_W-1:0]    isr_level;
    logic [VEC_W-1:0]      data_out;
    logic                  data_oe;
    logic                  spurious;
    logic                  busy;

    modport master (
        output irq_valid, irq_level, inta, vector_base, aeoi,
        input  int_out, isr_set, isr_clr, isr_level, data_out, data_oe, spurious, busy
    );

    modport slave (
        input  irq_valid, irq_level, inta, vector_base, aeoi,
        output int_out, isr_set, isr_clr, isr_level, data_out, data_oe, spurious, busy
    );

endinterface

// File: rtl/pic_edge_detect.sv
// Registers a synchronous strobe and flags its rising and falling edges.
// Latency: rise/fall are combinational against the one-cycle-old registered copy.
// Backpressure: none; every edge is reported exactly once.
module pic_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic din_d;
    logic din_q;

    // Next value of the delayed copy is simply the current input.
    always_comb begin
        din_d = din;
    end

    // Delayed copy of the strobe, cleared on reset so no edge is invented afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din_d;
        end
    end

    assign rise = din & ~din_q;
    assign fall = ~din & din_q;

endmodule

// File: rtl/inta_sequencer.sv
// Drives INT to the CPU and walks the two 8086-mode INTA pulses: ISR set, vector, optional auto-EOI.
// Latency: every output is registered; a sampled event is reflected one cycle later.
// Backpressure: none; the CPU paces via inta, a missing second pulse aborts after INTA_TIMEOUT cycles.
module inta_sequencer
    import pic_pkg::*;
#(
    parameter int INTA_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    inta_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(INTA_TIMEOUT - 1);

    logic inta_rise;
    logic inta_fall;

    pic_edge_detect u_inta_edge (
        .clk   (clk),
        .reset (reset),
        .din   (bus.inta),
        .rise  (inta_rise),
        .fall  (inta_fall)
    );

    state_t             state_d,     state_q;
    logic [LEVEL_W-1:0] level_d,     level_q;
    logic [CNT_W-1:0]   cnt_d,       cnt_q;
    logic               spur_d,      spur_q;
    logic               fall_seen_d, fall_seen_q;

    logic               int_out_d,   int_out_q;
    logic               isr_set_d,   isr_set_q;
    logic               isr_clr_d,   isr_clr_q;
    logic [LEVEL_W-1:0] isr_level_d, isr_level_q;
    logic [VEC_W-1:0]   data_out_d,  data_out_q;
    logic               data_oe_d,   data_oe_q;
    logic               spurious_d,  spurious_q;
    logic               busy_d,      busy_q;

    // Next-state and next-output logic; outputs are computed alongside the transition that causes them.
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        cnt_d       = cnt_q;
        spur_d      = spur_q;
        fall_seen_d = fall_seen_q;
        int_out_d   = 1'b0;
        isr_set_d   = 1'b0;
        isr_clr_d   = 1'b0;
        data_out_d  = '0;
        data_oe_d   = 1'b0;
        spurious_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d       = '0;
                spur_d      = 1'b0;
                fall_seen_d = 1'b0;
                if (bus.irq_valid) begin
                    state_d = REQ;
                end
            end

            REQ: begin
                if (inta_rise) begin
                    // First acknowledge: the request is frozen here; later resolver changes are ignored.
                    state_d     = ACK1;
                    cnt_d       = '0;
                    fall_seen_d = 1'b0;
                    if (bus.irq_valid) begin
                        level_d   = bus.irq_level;
                        isr_set_d = 1'b1;
                        spur_d    = 1'b0;
                    end else begin
                        // Request vanished under the acknowledge: answer with level 7, touch no ISR bit.
                        level_d    = SPURIOUS_LEVEL;
                        spurious_d = 1'b1;
                        spur_d     = 1'b1;
                    end
                end else if (!bus.irq_valid) begin
                    state_d = IDLE;
                end else begin
                    int_out_d = 1'b1;
                end
            end

            ACK1: begin
                if (inta_fall) begin
                    fall_seen_d = 1'b1;
                end
                // A second rise only counts once the first pulse has ended; it wins over a same-cycle timeout.
                if (inta_rise && fall_seen_q) begin
                    state_d    = ACK2;
                    cnt_d      = '0;
                    data_oe_d  = 1'b1;
                    data_out_d = make_vector(bus.vector_base, level_q);
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // Abandon the acknowledge; the ISR bit already set stays set.
                    state_d     = IDLE;
                    cnt_d       = '0;
                    spur_d      = 1'b0;
                    fall_seen_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ACK2: begin
                if (inta_fall) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    spur_d      = 1'b0;
                    fall_seen_d = 1'b0;
                    isr_clr_d   = bus.aeoi & ~spur_q;
                end else begin
                    data_oe_d  = 1'b1;
                    data_out_d = make_vector(bus.vector_base, level_q);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        isr_level_d = level_d;
        busy_d      = (state_d != IDLE);
    end

    // State, latched request context and registered outputs; reset overrides every transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            level_q     <= '0;
            cnt_q       <= '0;
            spur_q      <= 1'b0;
            fall_seen_q <= 1'b0;
            int_out_q   <= 1'b0;
            isr_set_q   <= 1'b0;
            isr_clr_q   <= 1'b0;
            isr_level_q <= '0;
            data_out_q  <= '0;
            data_oe_q   <= 1'b0;
            spurious_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            spur_q      <= spur_d;
            fall_seen_q <= fall_seen_d;
            int_out_q   <= int_out_d;
            isr_set_q   <= isr_set_d;
            isr_clr_q   <= isr_clr_d;
            isr_level_q <= isr_level_d;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
            spurious_q  <= spurious_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.int_out   = int_out_q;
    assign bus.isr_set   = isr_set_q;
    assign bus.isr_clr   = isr_clr_q;
    assign bus.isr_level = isr_level_q;
    assign bus.data_out  = data_out_q;
    assign bus.data_oe   = data_oe_q;
    assign bus.spurious  = spurious_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Self-checking bench for inta_sequencer: directed handshakes plus randomized acknowledges.
// Latency: outputs are sampled 1 time unit after the rising edge that produced them.
// Backpressure: the bench plays the CPU and paces the INTA pulses itself.
module tb_inta_sequencer;
    import pic_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    // Running totals of strobes and drive cycles, used to prove "exactly once" / "never".
    int mon_set  = 0;
    int mon_clr  = 0;
    int mon_spur = 0;
    int mon_oe   = 0;

    inta_sequencer_if bus ();

    inta_sequencer #(.INTA_TIMEOUT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [16:0] outs;
    assign outs = {bus.int_out, bus.isr_set, bus.isr_clr, bus.isr_level,
                   bus.data_out, bus.data_oe, bus.spurious, bus.busy};

    // Tally strobes on the falling edge, away from the active edge.
    always @(negedge clk) begin
        mon_set  <= mon_set  + int'(bus.isr_set);
        mon_clr  <= mon_clr  + int'(bus.isr_clr);
        mon_spur <= mon_spur + int'(bus.spurious);
        mon_oe   <= mon_oe   + int'(bus.data_oe);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete INT/INTA/INTA handshake. Expectations come from the protocol rules:
    // vector = base*8 + level (level 7 when spurious), one isr_set unless spurious,
    // isr_clr only for auto-EOI non-spurious, data driven for exactly the second pulse width.
    task automatic ack_transaction(input logic [2:0] lvl, input logic [4:0] base,
                                   input logic ae, input bit spur,
                                   input int w1, input int gap, input int w2, input bit chg);
        int         s_set, s_clr, s_spur, s_oe;
        int         exp_lvl, exp_vec;
        bit         exp_clr;
        s_set  = mon_set;
        s_clr  = mon_clr;
        s_spur = mon_spur;
        s_oe   = mon_oe;
        exp_lvl = spur ? 7 : int'(lvl);
        exp_vec = int'(base) * 8 + exp_lvl;
        exp_clr = ae && !spur;

        bus.irq_valid   = 1'b1;
        bus.irq_level   = lvl;
        bus.vector_base = base;
        bus.aeoi        = ae;
        step();
        checks++; if ({bus.int_out, bus.busy} !== 2'b01) begin errors++;
            $display("FAIL req_entry int_out/busy got %b want 01", {bus.int_out, bus.busy}); end
        step();
        checks++; if (bus.int_out !== 1'b1) begin errors++;
            $display("FAIL int_raise int_out got %b want 1", bus.int_out); end

        // First acknowledge pulse.
        bus.inta = 1'b1;
        if (spur) bus.irq_valid = 1'b0;
        step();
        checks++; if ({bus.int_out, bus.isr_set, bus.spurious} !== {1'b0, !spur, spur}) begin errors++;
            $display("FAIL ack1 int_out/isr_set/spurious got %b want %b",
                     {bus.int_out, bus.isr_set, bus.spurious}, {1'b0, !spur, spur}); end
        if (!spur) begin
            checks++; if (int'(bus.isr_level) !== exp_lvl) begin errors++;
                $display("FAIL set_level got %0d want %0d", bus.isr_level, exp_lvl); end
        end
        if (chg) begin
            bus.irq_level = 3'($urandom_range(0, 7));
            bus.irq_valid = 1'b1;
        end else begin
            bus.irq_valid = 1'b0;
        end
        for (int i = 1; i < w1; i++) step();
        bus.inta = 1'b0;
        for (int i = 0; i < gap; i++) step();

        // Second acknowledge pulse: vector on the bus for its whole width.
        bus.inta = 1'b1;
        for (int i = 0; i < w2; i++) begin
            step();
            checks++; if ({bus.data_oe, bus.data_out} !== {1'b1, 8'(exp_vec)}) begin errors++;
                $display("FAIL vector cyc%0d oe/data got %b/%h want 1/%h", i, bus.data_oe, bus.data_out, 8'(exp_vec)); end
        end
        bus.inta      = 1'b0;
        bus.irq_valid = 1'b0;
        step();
        checks++; if ({bus.data_oe, bus.isr_clr, bus.busy, bus.int_out} !== {1'b0, exp_clr, 1'b0, 1'b0}) begin errors++;
            $display("FAIL ack2_end oe/clr/busy/int got %b want %b",
                     {bus.data_oe, bus.isr_clr, bus.busy, bus.int_out}, {1'b0, exp_clr, 2'b00}); end
        if (exp_clr) begin
            checks++; if (int'(bus.isr_level) !== exp_lvl) begin errors++;
                $display("FAIL clr_level got %0d want %0d", bus.isr_level, exp_lvl); end
        end
        step();
        checks++; if (bus.isr_clr !== 1'b0) begin errors++;
            $display("FAIL clr_width isr_clr got %b want 0", bus.isr_clr); end
        step();
        checks++; if ({mon_set - s_set, mon_spur - s_spur, mon_clr - s_clr, mon_oe - s_oe} !==
                      {int'(!spur), int'(spur), int'(exp_clr), w2}) begin errors++;
            $display("FAIL strobe_counts set/spur/clr/oe got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                     mon_set - s_set, mon_spur - s_spur, mon_clr - s_clr, mon_oe - s_oe,
                     int'(!spur), int'(spur), int'(exp_clr), w2); end
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        bus.irq_valid   = 1'b0;
        bus.irq_level   = '0;
        bus.inta        = 1'b0;
        bus.vector_base = '0;
        bus.aeoi        = 1'b0;
        repeat (3) step();
        checks++; if (outs !== 17'h0) begin errors++;
            $display("FAIL reset_outputs got %h want 0", outs); end
        reset = 1'b0;
        repeat (2) step();
        checks++; if (outs !== 17'h0) begin errors++;
            $display("FAIL idle_outputs got %h want 0", outs); end
    endtask

    task automatic test_normal();
        ack_transaction(3'd3, 5'h08, 1'b0, 1'b0, 2, 2, 2, 1'b0);
    endtask

    task automatic test_aeoi();
        ack_transaction(3'd6, 5'h10, 1'b1, 1'b0, 1, 1, 3, 1'b0);
    endtask

    task automatic test_spurious();
        ack_transaction(3'd2, 5'h0a, 1'b1, 1'b1, 2, 1, 2, 1'b0);
    endtask

    task automatic test_timeout();
        int s_set, s_oe, s_clr;
        s_set = mon_set;
        s_oe  = mon_oe;
        s_clr = mon_clr;
        bus.irq_valid   = 1'b1;
        bus.irq_level   = 3'd5;
        bus.vector_base = 5'h1f;
        bus.aeoi        = 1'b1;
        step();
        step();
        bus.inta = 1'b1;
        step();
        checks++; if (bus.isr_set !== 1'b1) begin errors++;
            $display("FAIL timeout_set isr_set got %b want 1", bus.isr_set); end
        bus.irq_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 3) bus.inta = 1'b0;
            step();
            if (i == 9) begin
                checks++; if (bus.busy !== 1'b1) begin errors++;
                    $display("FAIL timeout_early busy got %b want 1", bus.busy); end
            end
        end
        checks++; if ({bus.busy, bus.data_oe, bus.int_out} !== 3'b000) begin errors++;
            $display("FAIL timeout_idle busy/oe/int got %b want 000", {bus.busy, bus.data_oe, bus.int_out}); end
        step();
        checks++; if ({mon_set - s_set, mon_oe - s_oe, mon_clr - s_clr} !== {32'd1, 32'd0, 32'd0}) begin errors++;
            $display("FAIL timeout_counts set/oe/clr got %0d/%0d/%0d want 1/0/0",
                     mon_set - s_set, mon_oe - s_oe, mon_clr - s_clr); end
    endtask

    task automatic test_level_change_reset();
        int s_clr;
        s_clr = mon_clr;
        bus.irq_valid   = 1'b1;
        bus.irq_level   = 3'd3;
        bus.vector_base = 5'h08;
        bus.aeoi        = 1'b1;
        step();
        step();
        bus.inta = 1'b1;
        step();
        bus.irq_level = 3'd1;
        step();
        bus.inta = 1'b0;
        step();
        bus.inta = 1'b1;
        step();
        checks++; if ({bus.data_oe, bus.data_out} !== {1'b1, 8'h43}) begin errors++;
            $display("FAIL level_frozen oe/data got %b/%h want 1/43", bus.data_oe, bus.data_out); end
        reset = 1'b1;
        step();
        checks++; if (outs !== 17'h0) begin errors++;
            $display("FAIL mid_ack_reset got %h want 0", outs); end
        bus.irq_valid = 1'b0;
        bus.inta      = 1'b0;
        step();
        reset = 1'b0;
        repeat (2) step();
        checks++; if ({outs, 32'(mon_clr - s_clr)} !== {17'h0, 32'd0}) begin errors++;
            $display("FAIL post_reset outs/clr got %h/%0d want 0/0", outs, mon_clr - s_clr); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            ack_transaction(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                            int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                            int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_aeoi();
        test_spurious();
        test_timeout();
        test_level_change_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
